// File: rtl/dmem_request_queue_pkg.sv
// Shared types and widths for the data-memory request queue.
// The request entry layout is fixed by the package widths below.
package dmem_req_pkg;

  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;

  typedef struct packed {
    logic                  wen;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] data;
  } dmem_req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } dmem_req_state_t;

endpackage

// File: rtl/dmem_request_queue_fifo.sv
// req_fifo: DEPTH-entry FIFO of request entries with push/pop, count and flags.
// A push is accepted only when not full, judged on count alone, so a pop in
// the same cycle never makes room for a push into a full FIFO.
module req_fifo
  import dmem_req_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = dmem_req_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  entry_t                     wdata,
  input  logic                       pop,
  output entry_t                     rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr];

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/dmem_request_queue.sv
// dmem_request_queue: queues dread/dwrite requests captured on ihit and issues
// them one at a time on dmemREN/dmemWEN, holding each until dhit.
// Optional feature macro: DMEM_REQ_TIMEOUT_EN (sticky timeout_err when a
// request sits in ISSUE for TIMEOUT_CYC cycles without dhit).
module dmem_request_queue
  import dmem_req_pkg::*;
#(
  parameter int ADDR_W      = REQ_ADDR_W,
  parameter int DATA_W      = REQ_DATA_W,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       iread,
  input  logic                       ihit,
  input  logic                       dread,
  input  logic                       dwrite,
  input  logic [ADDR_W-1:0]          daddr,
  input  logic [DATA_W-1:0]          dstore,
  input  logic                       dhit,
  output logic                       imemREN,
  output logic                       dmemREN,
  output logic                       dmemWEN,
  output logic [ADDR_W-1:0]          dmemaddr,
  output logic [DATA_W-1:0]          dmemstore,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       timeout_err
);

  dmem_req_state_t state;
  dmem_req_t       push_req;
  dmem_req_t       head_req;
  logic            q_push;
  logic            q_pop;
  logic            q_empty;

  assign imemREN = iread;

  // A simultaneous read and write is queued as a write.
  assign q_push        = ihit && (dread || dwrite);
  assign push_req.wen  = dwrite;
  assign push_req.addr = REQ_ADDR_W'(daddr);
  assign push_req.data = REQ_DATA_W'(dstore);

  assign q_pop = (state == IDLE) && !q_empty;
  assign empty = q_empty && (state == IDLE);

  req_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (dmem_req_t)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (q_push),
    .wdata (push_req),
    .pop   (q_pop),
    .rdata (head_req),
    .full  (full),
    .empty (q_empty),
    .count (count)
  );

  // Issue FSM: load the head entry from IDLE, hold it in ISSUE until dhit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      dmemREN   <= 1'b0;
      dmemWEN   <= 1'b0;
      dmemaddr  <= '0;
      dmemstore <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!q_empty) begin
            dmemaddr  <= ADDR_W'(head_req.addr);
            dmemstore <= DATA_W'(head_req.data);
            dmemREN   <= !head_req.wen;
            dmemWEN   <= head_req.wen;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (dhit) begin
            dmemREN <= 1'b0;
            dmemWEN <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_REQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt;

  // Stall counter for the request in flight; the error flag is sticky until RST.
  always_ff @(posedge CLK) begin
    if (RST) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (q_pop) begin
      to_cnt <= '0;
    end else if ((state == ISSUE) && !dhit) begin
      if (to_cnt == TO_W'(TIMEOUT_CYC-1)) timeout_err <= 1'b1;
      else                                to_cnt      <= to_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign timeout_err        = 1'b0;
`endif

endmodule
